uart_tx_arb: RTL and testbench

Packet-granular round-robin arbiter that shares the single `uart_tx` serializer among `N_SRC` byte-stream requesters, such as button-event reporters and status/heartbeat formatters. Each requester delivers a packet as a valid/ready byte stream terminated by `last`. The arbiter drives the serializer's `din`/`empty`/`re` port with correct byte spacing and never interleaves packets. A stall watchdog aborts a packet whose source stops supplying bytes mid-packet, so the UART cannot be held indefinitely.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/uart_tx_arb_rr_pick.sv | 33 +++
 rtl/uart_tx_arb.sv | 142 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and helpers for the UART transmit arbiter.
// Holds the arbiter FSM state encoding and the select-width helper.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    FETCH   = 2'd2
  } arb_state_t;

  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: combinational round-robin picker; scans req from ptr+1, wrapping.
// Ports: req (request vector), ptr (last grant) -> gnt (one-hot), idx.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 3,
  parameter int W = sel_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx
);

  int best;

  // Distance 0 is the source right after ptr; smallest distance wins.
  always_comb begin
    best = N;
    idx  = '0;
    gnt  = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && ((i + N - 1 - int'(ptr)) % N) < best) begin
        best = (i + N - 1 - int'(ptr)) % N;
        idx  = W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = (best < N) && (idx == W'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: packet-granular round-robin share of one uart_tx serializer.
// Ports: src_valid/data/last/ready streams in; din/empty/re to serializer.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int N_SRC     = 3,
  parameter int STALL_MAX = 27_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [8*N_SRC-1:0]         src_data,
  input  logic [N_SRC-1:0]           src_last,
  output logic [N_SRC-1:0]           src_ready,
  output logic [7:0]                 din,
  output logic                       empty,
  input  logic                       re,
  output logic                       busy,
  output logic [$clog2(N_SRC)-1:0]   grant_id,
  output logic                       abort,
  output logic [$clog2(N_SRC)-1:0]   abort_id
);

  localparam int SW = sel_w(N_SRC);
  localparam int CW = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] CMAX = CW'(STALL_MAX);

  arb_state_t      state, state_d;
  logic [7:0]      byte_q, cap_byte;
  logic            last_q, cap_last;
  logic [SW-1:0]   gnt_q, last_grant, abort_id_q;
  logic [SW-1:0]   pick_idx, cap_idx;
  logic [N_SRC-1:0] pick_gnt;
  logic            re_q, re_p;
  logic            abort_q, abort_d;
  logic [CW-1:0]   stall_cnt;
  logic            hs, fin, cnt_clr, cnt_inc;

  rr_pick #(
    .N (N_SRC),
    .W (SW)
  ) u_pick (
    .req (src_valid),
    .ptr (last_grant),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // A long re strobe counts once.
  assign re_p = re & ~re_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_q     <= 8'h00;
      last_q     <= 1'b0;
      gnt_q      <= '0;
      last_grant <= SW'(N_SRC - 1);
      abort_q    <= 1'b0;
      abort_id_q <= '0;
      re_q       <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      state   <= state_d;
      re_q    <= re;
      abort_q <= abort_d;
      if (abort_d) abort_id_q <= gnt_q;
      if (hs) begin
        byte_q <= cap_byte;
        last_q <= cap_last;
        gnt_q  <= cap_idx;
      end
      if (fin) last_grant <= gnt_q;
      if (cnt_clr) stall_cnt <= '0;
      else if (cnt_inc && stall_cnt != CMAX)
        stall_cnt <= stall_cnt + CW'(1);
    end
  end

  always_comb begin
    state_d = state;
    fin     = 1'b0;
    abort_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (hs) state_d = PRESENT;
      end
      PRESENT: begin
        if (re_p) begin
          if (last_q) begin
            state_d = IDLE;
            fin     = 1'b1;
          end else begin
            state_d = FETCH;
            cnt_clr = 1'b1;
          end
        end
      end
      FETCH: begin
        // A byte arriving on the limit cycle still wins.
        if (hs) begin
          state_d = PRESENT;
        end else if (stall_cnt == CMAX) begin
          state_d = IDLE;
          abort_d = 1'b1;
          fin     = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    src_ready = '0;
    unique case (state)
      IDLE:    src_ready = pick_gnt;
      FETCH:   src_ready[gnt_q] = 1'b1;
      default: src_ready = '0;
    endcase
    hs       = |(src_ready & src_valid);
    cap_idx  = (state == IDLE) ? pick_idx : gnt_q;
    cap_byte = 8'h00;
    cap_last = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_ready[i]) begin
        cap_byte = src_data[8*i +: 8];
        cap_last = src_last[i];
      end
    end
    din      = byte_q;
    empty    = (state != PRESENT);
    busy     = (state != IDLE);
    grant_id = gnt_q;
    abort    = abort_q;
    abort_id = abort_id_q;
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: vector table, directed corner sequences and a randomized
// run against a queue-based packet-arbitration reference model.
module tb_uart_tx_arb;

  localparam int N    = 3;
  localparam int SMAX = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   src_valid, src_last, src_ready;
  logic [8*N-1:0] src_data;
  logic [7:0]     din;
  logic           empty, re, busy, abort;
  logic [1:0]     grant_id, abort_id;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .N_SRC     (N),
    .STALL_MAX (SMAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_last  (src_last),
    .src_ready (src_ready),
    .din       (din),
    .empty     (empty),
    .re        (re),
    .busy      (busy),
    .grant_id  (grant_id),
    .abort     (abort),
    .abort_id  (abort_id)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic [2:0] v;
    logic       r;
    logic [2:0] rdy;
    logic       emp;
    logic       bsy;
    logic [1:0] gid;
    logic [7:0] d;
  } vec_t;

  vec_t tbl [11];

  // Reference model: packet queues per source, one owner at a time.
  logic [8:0] q [N][$];
  int         gap [N];
  bit         gate_rand;
  int         re_mode;
  bit         re_man;
  int         m_owner, m_gid, m_ptr, cyc;
  bit         m_hold, m_last, re_prev, h_prev;
  logic [7:0] m_din;
  int         ua, ub, pa, pb;
  logic [7:0] cons_byte [$];
  int         cons_src [$];

  task automatic model_reset();
    m_owner = -1; m_gid = 0; m_ptr = N - 1;
    m_hold = 0; m_last = 0; re_prev = 0; h_prev = 0;
    m_din = 8'h00;
    ua = -100; ub = -100; pa = -100; pb = -100;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      gap[i] = 0;
    end
    cons_byte.delete();
    cons_src.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src_valid = '0; src_last = '0; src_data = '0; re = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic int pick();
    for (int k = 1; k <= N; k++)
      if (src_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic take(input int g);
    logic [8:0] f;
    f = q[g].pop_front();
    m_owner = g; m_gid = g;
    m_din = f[7:0]; m_last = f[8]; m_hold = 1;
  endtask

  task automatic cycle();
    logic [N-1:0] er;
    logic [8:0]   f;
    int           pk;
    bit           v, rp;
    for (int i = 0; i < N; i++) begin
      v = q[i].size() > 0;
      if (v && gate_rand && gap[i] < 4 && $urandom_range(0, 3) == 0) v = 0;
      gap[i] = v ? 0 : gap[i] + 1;
      f = v ? q[i][0] : 9'h000;
      src_valid[i] = v;
      src_data[8*i +: 8] = f[7:0];
      src_last[i] = f[8];
    end
    if (m_hold && !h_prev) begin
      pa = ua; pb = ub; ua = cyc + 5; ub = cyc + 7;
    end
    h_prev = m_hold;
    case (re_mode)
      0: re = (cyc >= ua && cyc <= ub) || (cyc >= pa && cyc <= pb);
      1: re = ($urandom_range(0, 2) == 0);
      default: re = re_man;
    endcase
    er = '0;
    pk = pick();
    if (m_owner < 0) begin
      if (pk >= 0) er[pk] = 1'b1;
    end else if (!m_hold) begin
      er[m_owner] = 1'b1;
    end
    #1;
    chk("src_ready", src_ready, er);
    chk("empty", empty, !m_hold);
    chk("busy", busy, m_owner >= 0);
    chk("din", din, m_din);
    chk("grant_id", grant_id, m_gid);
    chk("abort", abort, 0);
    rp = re && !re_prev;
    re_prev = re;
    if (m_owner < 0) begin
      if (pk >= 0) take(pk);
    end else if (m_hold) begin
      if (rp) begin
        cons_byte.push_back(din);
        cons_src.push_back(int'(grant_id));
        m_hold = 0;
        if (m_last) begin
          m_ptr = m_owner;
          m_owner = -1;
        end
      end
    end else if (src_valid[m_owner]) begin
      take(m_owner);
    end
    tick();
    cyc++;
  endtask

  task automatic ptr_to_src0();
    src_valid = 3'b001; src_last = 3'b001; src_data = 24'h00000A; re = 0;
    tick();
    src_valid = 3'b000; re = 1;
    tick();
    re = 0;
  endtask

  logic [7:0] exp_b [$];
  int         pushed, left;

  initial begin
    tbl[0]  = '{3'b111, 1'b0, 3'b001, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{3'b111, 1'b1, 3'b000, 1'b0, 1'b1, 2'd0, 8'hA0};
    tbl[2]  = '{3'b111, 1'b1, 3'b010, 1'b1, 1'b0, 2'd0, 8'hA0};
    tbl[3]  = '{3'b111, 1'b1, 3'b000, 1'b0, 1'b1, 2'd1, 8'hB1};
    tbl[4]  = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 2'd1, 8'hB1};
    tbl[5]  = '{3'b111, 1'b1, 3'b000, 1'b0, 1'b1, 2'd1, 8'hB1};
    tbl[6]  = '{3'b111, 1'b0, 3'b100, 1'b1, 1'b0, 2'd1, 8'hB1};
    tbl[7]  = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 2'd2, 8'hC2};
    tbl[8]  = '{3'b111, 1'b1, 3'b000, 1'b0, 1'b1, 2'd2, 8'hC2};
    tbl[9]  = '{3'b111, 1'b1, 3'b001, 1'b1, 1'b0, 2'd2, 8'hC2};
    tbl[10] = '{3'b111, 1'b0, 3'b000, 1'b0, 1'b1, 2'd0, 8'hA0};
    cyc = 0; gate_rand = 0; re_mode = 0; re_man = 0;

    // Reset values
    do_reset();
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_din", din, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_abort", {abort, abort_id}, 0);
    tick();

    // Round robin of 1-byte packets, held re
    do_reset();
    src_data = 24'hC2B1A0; src_last = 3'b111;
    for (int i = 0; i < 11; i++) begin
      src_valid = tbl[i].v; re = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d_rdy", i), src_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_emp", i), empty, tbl[i].emp);
      chk($sformatf("tbl%0d_bsy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_gid", i), grant_id, tbl[i].gid);
      chk($sformatf("tbl%0d_din", i), din, tbl[i].d);
      tick();
    end

    // Single packet with slow UART
    do_reset();
    re_mode = 0;
    q[0].push_back(9'h04F); q[0].push_back(9'h04B);
    q[0].push_back(9'h00D); q[0].push_back(9'h10A);
    for (int t = 0; t < 200 && !(cons_byte.size() == 4 && m_owner < 0); t++)
      cycle();
    repeat (3) cycle();
    exp_b = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};
    chk("single_cnt", cons_byte.size(), 4);
    for (int i = 0; i < 4 && i < cons_byte.size(); i++)
      chk($sformatf("single_b%0d", i), cons_byte[i], exp_b[i]);

    // Simultaneous requests: whole src0 packet, then src1
    do_reset();
    q[0].push_back(9'h010); q[0].push_back(9'h011); q[0].push_back(9'h112);
    q[1].push_back(9'h020); q[1].push_back(9'h021); q[1].push_back(9'h122);
    for (int t = 0; t < 300 && !(cons_byte.size() == 6 && m_owner < 0); t++)
      cycle();
    exp_b = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22};
    chk("simul_cnt", cons_byte.size(), 6);
    for (int i = 0; i < 6 && i < cons_byte.size(); i++) begin
      chk($sformatf("simul_b%0d", i), cons_byte[i], exp_b[i]);
      chk($sformatf("simul_s%0d", i), cons_src[i], i < 3 ? 0 : 1);
    end

    // Long re: one byte per strobe, owner unchanged
    do_reset();
    re_mode = 2; re_man = 0;
    q[0].push_back(9'h030); q[0].push_back(9'h131);
    q[1].push_back(9'h140);
    repeat (2) cycle();
    re_man = 1;
    repeat (20) cycle();
    chk("longre_cnt", cons_byte.size(), 1);
    chk("longre_gid", grant_id, 0);
    chk("longre_din", din, 8'h31);
    re_man = 0;
    cycle();
    re_mode = 1;
    for (int t = 0; t < 300 && !(cons_byte.size() == 3 && m_owner < 0); t++)
      cycle();
    chk("longre_done", cons_byte.size(), 3);

    // Randomized traffic
    do_reset();
    gate_rand = 1; re_mode = 1; pushed = 0;
    for (int t = 0; t < 5000; t++) begin
      if (pushed < 40 && $urandom_range(0, 5) == 0) begin
        automatic int s = $urandom_range(0, N - 1);
        automatic int len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++)
          q[s].push_back({j == len - 1, 8'($urandom)});
        pushed++;
      end
      left = 0;
      for (int i = 0; i < N; i++) left += q[i].size();
      if (pushed == 40 && left == 0 && m_owner < 0) break;
      cycle();
    end
    left = 0;
    for (int i = 0; i < N; i++) left += q[i].size();
    chk("rand_left", left + (m_owner >= 0 ? 1 : 0), 0);
    gate_rand = 0;

    // Stall: t=0 aborts, t=1 byte arrives on the limit cycle
    for (int t = 0; t < 2; t++) begin
      do_reset();
      ptr_to_src0();
      src_valid = 3'b100; src_last = 3'b000; src_data = 24'h55000A;
      #1;
      chk("stall_grant", src_ready, 3'b100);
      tick();
      src_valid = 3'b000; re = 1;
      #1;
      chk("stall_pres", {grant_id, din}, {2'd2, 8'h55});
      tick();
      re = 0;
      for (int k = 0; k < SMAX; k++) begin
        #1;
        chk($sformatf("stall_wait%0d", k),
            {busy, empty, abort, src_ready}, 6'b110100);
        tick();
      end
      if (t == 1) begin
        src_valid = 3'b100; src_last = 3'b100; src_data = 24'h66000A;
      end
      #1;
      chk("stall_lim", {abort, src_ready}, 4'b0100);
      tick();
      src_valid = 3'b000;
      #1;
      if (t == 0) begin
        chk("abort_pulse", {abort, abort_id, busy, empty}, 5'b11001);
        tick();
        #1;
        chk("abort_one", abort, 0);
        src_valid = 3'b011;
        #1;
        chk("after_abort", src_ready, 3'b001);
      end else begin
        chk("late_byte", {abort, busy, empty, din}, {3'b010, 8'h66});
      end
      src_valid = 3'b000;
      tick();
    end

    // Reset mid-packet
    do_reset();
    ptr_to_src0();
    src_valid = 3'b010; src_last = 3'b000; src_data = 24'h007700;
    tick();
    src_valid = 3'b000;
    #1;
    chk("mid_pres", {busy, empty, grant_id}, 4'b1001);
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("mid_rst", {empty, busy, src_ready, grant_id, din}, 15'h4000);
    src_valid = 3'b011; src_last = 3'b011; src_data = 24'h00770B;
    #1;
    chk("mid_rr", src_ready, 3'b001);
    tick();
    src_valid = 3'b000;
    #1;
    chk("mid_gnt", {grant_id, din}, {2'd0, 8'h0B});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
